// File: rtl/store_buffer_pkg.sv
// Shared LSU definitions for the store buffer: the entry record, the byte-count
// constant and the helper that maps a word width to its byte-offset bit count.
package store_buffer_pkg;

    localparam int SB_WORDLEN_MAX = 64;
    localparam int SB_PA_BITS_MAX = 56;
    localparam int SB_BYTES       = SB_WORDLEN_MAX / 8;

    // Sized for the widest supported configuration; narrower builds use the low bits.
    typedef struct packed {
        logic                      valid;
        logic [SB_PA_BITS_MAX-1:0] adr;
        logic [SB_WORDLEN_MAX-1:0] data;
        logic [SB_BYTES-1:0]       mask;
    } sb_entry_t;

    function automatic int sb_off_bits(input int wordlen);
        return $clog2(wordlen / 8);
    endfunction

endpackage

// File: rtl/store_buffer_entry.sv
// One store-buffer slot: allocate writes the whole record, merge replaces only the
// enabled bytes and ORs the byte mask, clear retires the slot on drain.
module store_buffer_entry
    import store_buffer_pkg::*;
#(
    parameter int WORDLEN = 64,
    parameter int PA_BITS = 56
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_alloc,
    input  logic                 i_merge,
    input  logic                 i_clear,
    input  logic [PA_BITS-1:0]   i_adr,
    input  logic [WORDLEN-1:0]   i_data,
    input  logic [WORDLEN/8-1:0] i_mask,
    output sb_entry_t            o_entry
);

    localparam int BYTES = WORDLEN / 8;

    logic               r_valid;
    logic [PA_BITS-1:0] r_adr;
    logic [WORDLEN-1:0] r_data;
    logic [BYTES-1:0]   r_mask;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= 1'b0;
        end else if (i_alloc) begin
            r_valid <= 1'b1;
        end else if (i_clear) begin
            r_valid <= 1'b0;
        end
    end

    // Payload is never reset; the valid bit alone decides whether it is meaningful.
    always_ff @(posedge clk) begin
        if (i_alloc) begin
            r_adr  <= i_adr;
            r_mask <= i_mask;
        end else if (i_merge) begin
            r_mask <= r_mask | i_mask;
        end
        for (int b = 0; b < BYTES; b++) begin
            if (i_alloc || (i_merge && i_mask[b])) begin
                r_data[8*b +: 8] <= i_data[8*b +: 8];
            end
        end
    end

    always_comb begin
        o_entry       = '0;
        o_entry.valid = r_valid;
        o_entry.adr   = SB_PA_BITS_MAX'(r_adr);
        o_entry.data  = SB_WORDLEN_MAX'(r_data);
        o_entry.mask  = SB_BYTES'(r_mask);
    end

endmodule

// File: rtl/store_buffer.sv
// Circular store buffer between the LSU and memory: coalesces stores to the newest
// word, drains from the head, and flags loads that hit a buffered word.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int WORDLEN = 64,
    parameter int DEPTH   = 4,
    parameter int PA_BITS = 56
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 StoreValid,
    output logic                 StoreReady,
    input  logic [PA_BITS-1:0]   StoreAdr,
    input  logic [WORDLEN-1:0]   StoreData,
    input  logic [WORDLEN/8-1:0] StoreByteMask,
    output logic                 DrainValid,
    input  logic                 DrainReady,
    output logic [PA_BITS-1:0]   DrainAdr,
    output logic [WORDLEN-1:0]   DrainData,
    output logic [WORDLEN/8-1:0] DrainByteMask,
    input  logic [PA_BITS-1:0]   LoadAdr,
    output logic                 LoadHazard,
    output logic                 Empty
);

    localparam int BYTES = WORDLEN / 8;
    localparam int OFF   = sb_off_bits(WORDLEN);
    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = $clog2(DEPTH + 1);

    logic [AW-1:0]      r_head;
    logic [AW-1:0]      r_tail;
    logic [CW-1:0]      r_count;

    sb_entry_t          w_entry [DEPTH];
    sb_entry_t          w_head_e;
    sb_entry_t          w_newest_e;
    logic [AW-1:0]      w_newest;
    logic [PA_BITS-1:0] w_store_wadr;
    logic               w_merge_ok;
    logic               w_store_fire;
    logic               w_alloc;
    logic               w_merge;
    logic               w_drain;
    logic               w_unused_adr_lsbs;

    assign w_newest     = r_tail - AW'(1);
    assign w_head_e     = w_entry[r_head];
    assign w_newest_e   = w_entry[w_newest];
    assign w_store_wadr = {StoreAdr[PA_BITS-1:OFF], {OFF{1'b0}}};
    assign w_unused_adr_lsbs = ^{StoreAdr[OFF-1:0], LoadAdr[OFF-1:0]};

    // With count>=2 the newest entry is never the head, so merging leaves drain outputs stable.
    assign w_merge_ok   = (r_count >= CW'(2)) &&
                          (w_newest_e.adr[PA_BITS-1:OFF] == StoreAdr[PA_BITS-1:OFF]);
    assign StoreReady   = (r_count < CW'(DEPTH)) || w_merge_ok;
    assign w_store_fire = StoreValid && StoreReady;
    assign w_merge      = w_store_fire && w_merge_ok;
    assign w_alloc      = w_store_fire && !w_merge_ok;

    assign DrainValid    = (r_count != '0);
    assign w_drain       = DrainValid && DrainReady;
    assign Empty         = (r_count == '0);
    assign DrainAdr      = w_head_e.adr[PA_BITS-1:0];
    assign DrainData     = w_head_e.data[WORDLEN-1:0];
    assign DrainByteMask = w_head_e.mask[BYTES-1:0];

    always_comb begin
        LoadHazard = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_entry[i].valid &&
                (w_entry[i].adr[PA_BITS-1:OFF] == LoadAdr[PA_BITS-1:OFF]) &&
                !(w_drain && (r_head == AW'(i)))) begin
                LoadHazard = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_drain) begin
                r_head <= r_head + AW'(1);
            end
            if (w_alloc) begin
                r_tail <= r_tail + AW'(1);
            end
            r_count <= r_count + CW'(w_alloc) - CW'(w_drain);
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_entry
        store_buffer_entry #(
            .WORDLEN (WORDLEN),
            .PA_BITS (PA_BITS)
        ) u_entry (
            .clk     (clk),
            .reset   (reset),
            .i_alloc (w_alloc && (r_tail == AW'(g))),
            .i_merge (w_merge && (w_newest == AW'(g))),
            .i_clear (w_drain && (r_head == AW'(g))),
            .i_adr   (w_store_wadr),
            .i_data  (StoreData),
            .i_mask  (StoreByteMask),
            .o_entry (w_entry[g])
        );
    end

endmodule
